// File: rtl/field_port_arbiter_if.sv
// Request, grant, read-return and RAM-side signals shared by one field arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the RAM.
interface field_port_arbiter_if #(
    parameter int FIELD_W = 64,
    parameter int FIELD_H = 48
);
    localparam int X_ADR_SIZE = $clog2(FIELD_W);
    localparam int Y_ADR_SIZE = $clog2(FIELD_H);

    logic                  i_disp_req;
    logic [X_ADR_SIZE-1:0] i_disp_x;
    logic [Y_ADR_SIZE-1:0] i_disp_y;
    logic                  o_disp_gnt;
    logic                  o_disp_rvalid;

    logic                  i_edit_req;
    logic                  i_edit_we;
    logic                  i_edit_wdata;
    logic [X_ADR_SIZE-1:0] i_edit_x;
    logic [Y_ADR_SIZE-1:0] i_edit_y;
    logic                  o_edit_gnt;
    logic                  o_edit_rvalid;

    logic                  i_sim_req;
    logic                  i_sim_we;
    logic                  i_sim_wdata;
    logic [X_ADR_SIZE-1:0] i_sim_x;
    logic [Y_ADR_SIZE-1:0] i_sim_y;
    logic                  o_sim_gnt;
    logic                  o_sim_rvalid;

    logic [X_ADR_SIZE-1:0] o_ram_x;
    logic [Y_ADR_SIZE-1:0] o_ram_y;
    logic                  o_ram_w_en;
    logic                  o_ram_wdata;
    logic                  i_ram_rdata;
    logic                  o_rdata;

    modport slave (
        input  i_disp_req, i_disp_x, i_disp_y,
        input  i_edit_req, i_edit_we, i_edit_wdata, i_edit_x, i_edit_y,
        input  i_sim_req, i_sim_we, i_sim_wdata, i_sim_x, i_sim_y,
        input  i_ram_rdata,
        output o_disp_gnt, o_disp_rvalid, o_edit_gnt, o_edit_rvalid,
        output o_sim_gnt, o_sim_rvalid,
        output o_ram_x, o_ram_y, o_ram_w_en, o_ram_wdata, o_rdata
    );

    modport master (
        output i_disp_req, i_disp_x, i_disp_y,
        output i_edit_req, i_edit_we, i_edit_wdata, i_edit_x, i_edit_y,
        output i_sim_req, i_sim_we, i_sim_wdata, i_sim_x, i_sim_y,
        output i_ram_rdata,
        input  o_disp_gnt, o_disp_rvalid, o_edit_gnt, o_edit_rvalid,
        input  o_sim_gnt, o_sim_rvalid,
        input  o_ram_x, o_ram_y, o_ram_w_en, o_ram_wdata, o_rdata
    );
endinterface

// File: rtl/field_port_arbiter.sv
// Fixed-priority arbiter (display > editor > simulation) for one field RAM port,
// with a starvation counter that lets the simulation controller overtake the editor.
module field_port_arbiter #(
    parameter int FIELD_W  = 64,
    parameter int FIELD_H  = 48,
    parameter int MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    field_port_arbiter_if.slave  bus
);
    localparam int X_ADR_SIZE = $clog2(FIELD_W);
    localparam int Y_ADR_SIZE = $clog2(FIELD_H);
    localparam int CNT_W      = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]    MAX_CNT = CNT_W'(MAX_WAIT);
    localparam logic [X_ADR_SIZE:0] X_LIM   = (X_ADR_SIZE + 1)'(FIELD_W);
    localparam logic [Y_ADR_SIZE:0] Y_LIM   = (Y_ADR_SIZE + 1)'(FIELD_H);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [2:0]       owner_q, owner_d;
    logic             oor_q, oor_d;

    logic                  disp_gnt, edit_gnt, sim_gnt, sim_priority;
    logic [X_ADR_SIZE-1:0] ram_x;
    logic [Y_ADR_SIZE-1:0] ram_y;
    logic                  ram_we, ram_wdata, addr_oor;
    logic [2:0]            rd_owner;

    always_comb begin
        sim_priority = bus.i_sim_req && (starve_cnt_q == MAX_CNT);
        disp_gnt = bus.i_disp_req;
        edit_gnt = bus.i_edit_req && !bus.i_disp_req && !sim_priority;
        sim_gnt  = bus.i_sim_req && !bus.i_disp_req && (!bus.i_edit_req || sim_priority);

        ram_x     = '0;
        ram_y     = '0;
        ram_we    = 1'b0;
        ram_wdata = 1'b0;
        if (disp_gnt) begin
            ram_x = bus.i_disp_x;
            ram_y = bus.i_disp_y;
        end else if (edit_gnt) begin
            ram_x     = bus.i_edit_x;
            ram_y     = bus.i_edit_y;
            ram_we    = bus.i_edit_we;
            ram_wdata = bus.i_edit_wdata;
        end else if (sim_gnt) begin
            ram_x     = bus.i_sim_x;
            ram_y     = bus.i_sim_y;
            ram_we    = bus.i_sim_we;
            ram_wdata = bus.i_sim_wdata;
        end

        addr_oor = ({1'b0, ram_x} >= X_LIM) || ({1'b0, ram_y} >= Y_LIM);
        rd_owner = {sim_gnt && !bus.i_sim_we, edit_gnt && !bus.i_edit_we, disp_gnt};
        owner_d  = rd_owner;
        oor_d    = addr_oor && (rd_owner != 3'b000);

        // Counter only runs while the simulation controller is actually being refused.
        if (!bus.i_sim_req || sim_gnt) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q < MAX_CNT) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
            owner_q      <= '0;
            oor_q        <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
            oor_q        <= oor_d;
        end
    end

    logic [2:0] rvalid;
    for (genvar gi = 0; gi < 3; gi++) begin : g_rvalid
        assign rvalid[gi] = owner_q[gi];
    end

    assign bus.o_disp_gnt    = disp_gnt;
    assign bus.o_edit_gnt    = edit_gnt;
    assign bus.o_sim_gnt     = sim_gnt;
    assign bus.o_disp_rvalid = rvalid[0];
    assign bus.o_edit_rvalid = rvalid[1];
    assign bus.o_sim_rvalid  = rvalid[2];
    assign bus.o_ram_x       = ram_x;
    assign bus.o_ram_y       = ram_y;
    assign bus.o_ram_wdata   = ram_wdata;
    // Writes to cells outside the field, and all writes during reset, are dropped.
    assign bus.o_ram_w_en    = ram_we && !addr_oor && !rst;
    assign bus.o_rdata       = (owner_q != 3'b000) && !oor_q && bus.i_ram_rdata;
endmodule

// File: tb/tb_field_port_arbiter.sv
// Randomised scoreboard bench for field_port_arbiter with a behavioural field model
// and a 1-cycle-latency RAM attached to the arbiter's port.
module tb_field_port_arbiter;
    localparam int FW = 40;
    localparam int FH = 24;
    localparam int MW = 4;
    localparam int XA = $clog2(FW);
    localparam int YA = $clog2(FH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    field_port_arbiter_if #(.FIELD_W(FW), .FIELD_H(FH)) bus ();
    field_port_arbiter #(.FIELD_W(FW), .FIELD_H(FH), .MAX_WAIT(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM attached to the port; cells outside the field read back as 1.
    logic ram_mem [0:(2**(XA+YA))-1];
    always @(posedge clk) begin
        if (bus.o_ram_w_en) ram_mem[{bus.o_ram_y, bus.o_ram_x}] <= bus.o_ram_wdata;
        if (int'(bus.o_ram_x) >= FW || int'(bus.o_ram_y) >= FH)
            bus.i_ram_rdata <= 1'b1;
        else if (bus.o_ram_w_en)
            bus.i_ram_rdata <= bus.o_ram_wdata;
        else
            bus.i_ram_rdata <= ram_mem[{bus.o_ram_y, bus.o_ram_x}];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    typedef struct {
        logic [2:0] owner;
        logic       data;
        int         due;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state
    bit model_mem [0:FH-1][0:FW-1];
    int model_starve = 0;

    always @(negedge clk) begin
        logic [2:0] rv;
        exp_t e;
        rv = {bus.o_sim_rvalid, bus.o_edit_rvalid, bus.o_disp_rvalid};
        if (rv != 3'b000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", int'(rv), 0);
            end else begin
                e = exp_q.pop_front();
                chk("rvalid_owner", int'(rv), int'(e.owner));
                chk("rdata", int'(bus.o_rdata), int'(e.data));
                chk("rvalid_cycle", cyc, e.due);
            end
        end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            chk("missing_rvalid", 0, int'(e.owner));
        end
    end

    task automatic step(
        input bit r,
        input bit dr, input int dx, input int dy,
        input bit er, input bit ewe, input bit ewd, input int ex, input int ey,
        input bit sr, input bit swe, input bit swd, input int sx, input int sy);
        int win, wx, wy;
        bit wwe, wwd, oor, exp_wen;
        exp_t e;
        @(negedge clk);
        rst = r;
        bus.i_disp_req = dr; bus.i_disp_x = XA'(dx); bus.i_disp_y = YA'(dy);
        bus.i_edit_req = er; bus.i_edit_we = ewe; bus.i_edit_wdata = ewd;
        bus.i_edit_x = XA'(ex); bus.i_edit_y = YA'(ey);
        bus.i_sim_req = sr; bus.i_sim_we = swe; bus.i_sim_wdata = swd;
        bus.i_sim_x = XA'(sx); bus.i_sim_y = YA'(sy);
        #1;
        // winner: 0 none, 1 display, 2 editor, 3 simulation
        if (dr) win = 1;
        else if (er && sr) win = (model_starve == MW) ? 3 : 2;
        else if (er) win = 2;
        else if (sr) win = 3;
        else win = 0;
        case (win)
            1: begin wx = dx; wy = dy; wwe = 0;   wwd = 0;   end
            2: begin wx = ex; wy = ey; wwe = ewe; wwd = ewd; end
            3: begin wx = sx; wy = sy; wwe = swe; wwd = swd; end
            default: begin wx = 0; wy = 0; wwe = 0; wwd = 0; end
        endcase
        oor = (wx >= FW) || (wy >= FH);
        exp_wen = wwe && !oor && !r;
        chk("grants", int'({bus.o_sim_gnt, bus.o_edit_gnt, bus.o_disp_gnt}),
            (win == 0) ? 0 : (1 << (win - 1)));
        chk("ram_x", int'(bus.o_ram_x), wx);
        chk("ram_y", int'(bus.o_ram_y), wy);
        chk("ram_w_en", int'(bus.o_ram_w_en), int'(exp_wen));
        if (exp_wen) chk("ram_wdata", int'(bus.o_ram_wdata), int'(wwd));
        chk("starve_cnt", int'(dut.starve_cnt_q), model_starve);
        if (win != 0 && !wwe && !r) begin
            e.owner = 3'(1 << (win - 1));
            e.data  = oor ? 1'b0 : model_mem[wy][wx];
            e.due   = cyc + 1;
            exp_q.push_back(e);
        end
        if (exp_wen) model_mem[wy][wx] = wwd;
        if (r || !sr || win == 3) model_starve = 0;
        else if (model_starve < MW) model_starve++;
    endtask

    task automatic idle(input bit r);
        step(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int rnd_x();
        return ($urandom_range(7) == 0) ? int'($urandom_range(2**XA - 1, FW)) : int'($urandom_range(FW - 1));
    endfunction
    function automatic int rnd_y();
        return ($urandom_range(7) == 0) ? int'($urandom_range(2**YA - 1, FH)) : int'($urandom_range(FH - 1));
    endfunction

    initial begin
        for (int i = 0; i < 2**(XA+YA); i++) ram_mem[i] = 1'b0;
        bus.i_disp_req = 0; bus.i_disp_x = '0; bus.i_disp_y = '0;
        bus.i_edit_req = 0; bus.i_edit_we = 0; bus.i_edit_wdata = 0;
        bus.i_edit_x = '0; bus.i_edit_y = '0;
        bus.i_sim_req = 0; bus.i_sim_we = 0; bus.i_sim_wdata = 0;
        bus.i_sim_x = '0; bus.i_sim_y = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_rvalid", int'({bus.o_sim_rvalid, bus.o_edit_rvalid, bus.o_disp_rvalid}), 0);
        chk("reset_rdata", int'(bus.o_rdata), 0);
        chk("reset_starve", int'(dut.starve_cnt_q), 0);
        idle(1);
        idle(0);

        // Display read of a cell previously set by the editor
        step(0, 0, 0, 0, 1, 1, 1, 3, 2, 0, 0, 0, 0, 0);
        step(0, 1, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        // Editor write then simulation read of the same cell next cycle
        step(0, 0, 0, 0, 1, 1, 1, 5, 5, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5, 5);
        idle(0);
        // Continuous editor and simulation contention
        for (int i = 0; i < 11; i++) step(0, 0, 0, 0, 1, 0, 0, i, 1, 1, 0, 0, i, 3);
        idle(0);
        // All three, then display released
        step(0, 1, 1, 1, 1, 0, 0, 5, 5, 1, 0, 0, 3, 2);
        step(0, 0, 0, 0, 1, 0, 0, 5, 5, 1, 0, 0, 3, 2);
        idle(0);
        // Out-of-range accesses
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, FW, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, FH, 0, 0, 0, 0, 0);
        idle(0);
        // Reset around reads and writes
        step(0, 1, 3, 2, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
        idle(1);
        idle(0);
        step(1, 0, 0, 0, 1, 1, 0, 3, 2, 0, 0, 0, 0, 0);
        step(1, 1, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        step(0, 1, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(63) == 0),
                 ($urandom_range(3) == 0), rnd_x(), rnd_y(),
                 ($urandom_range(1) == 0), 1'($urandom_range(1)), 1'($urandom_range(1)), rnd_x(), rnd_y(),
                 ($urandom_range(1) == 0), 1'($urandom_range(1)), 1'($urandom_range(1)), rnd_x(), rnd_y());
        end
        idle(0);
        idle(0);
        idle(0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
